// File: rtl/screen_arb_pkg.sv
// Shared definitions for the screen RAM arbiter: FSM encoding and default widths.
package screen_arb_pkg;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_WAIT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_RDATA = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/sat_max_counter.sv
// Saturating event counter with a running-maximum register; the maximum is
// folded in on commit so callers decide when an interval ends.
module sat_max_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic             commit,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] max_value
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] max_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
            max_reg   <= '0;
        end else begin
            if (clear)
                count_reg <= '0;
            else if (inc && (count_reg != {WIDTH{1'b1}}))
                count_reg <= count_reg + 1'b1;
            if (commit && (count_reg > max_reg))
                max_reg <= count_reg;
        end
    end

    assign count     = count_reg;
    assign max_value = max_reg;

endmodule

// File: rtl/screen_ram_arbiter.sv
// Single-port screen RAM shared by the VGA pixel fetch (absolute priority) and
// a one-deep CPU command slot serviced whenever the renderer is not reading.
module screen_ram_arbiter
    import screen_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int WAIT_WIDTH = DEF_WAIT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vga_read_en,
    input  logic [ADDR_WIDTH-1:0] vga_read_addr,
    output logic [DATA_WIDTH-1:0] vga_read_data,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_busy,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_overrun,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [WAIT_WIDTH-1:0] stat_max_wait
);

    arb_state_t            state_reg;
    logic                  cmd_we_reg;
    logic [ADDR_WIDTH-1:0] cmd_addr_reg;
    logic [DATA_WIDTH-1:0] cmd_wdata_reg;
    logic [DATA_WIDTH-1:0] cpu_rdata_reg;
    logic                  overrun_reg;
    logic                  prev_vga_reg;
    logic [DATA_WIDTH-1:0] vga_hold_reg;
    logic [WAIT_WIDTH-1:0] wait_count;

    logic in_idle;
    logic in_pend;
    logic pend_grant;

    assign in_idle    = (state_reg == ST_IDLE);
    assign in_pend    = (state_reg == ST_PEND);
    assign pend_grant = in_pend & ~vga_read_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cmd_we_reg    <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            cpu_rdata_reg <= '0;
            overrun_reg   <= 1'b0;
            prev_vga_reg  <= 1'b0;
            vga_hold_reg  <= '0;
        end else begin
            prev_vga_reg <= vga_read_en;
            if (prev_vga_reg)
                vga_hold_reg <= ram_rdata;
            // Any request outside IDLE (ACK included) is dropped and flagged.
            if (cpu_req && !in_idle)
                overrun_reg <= 1'b1;
            case (state_reg)
                ST_IDLE: begin
                    if (cpu_req) begin
                        cmd_we_reg    <= cpu_we;
                        cmd_addr_reg  <= cpu_addr;
                        cmd_wdata_reg <= cpu_wdata;
                        state_reg     <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!vga_read_en)
                        state_reg <= cmd_we_reg ? ST_ACK : ST_RDATA;
                end
                ST_RDATA: begin
                    cpu_rdata_reg <= ram_rdata;
                    state_reg     <= ST_ACK;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    sat_max_counter #(
        .WIDTH(WAIT_WIDTH)
    ) u_wait_stat (
        .clk       (clk),
        .reset     (reset),
        .clear     (in_idle & cpu_req),
        .inc       (in_pend & vga_read_en),
        .commit    (pend_grant),
        .count     (wait_count),
        .max_value (stat_max_wait)
    );

    // The renderer owns the address bus whenever it strobes; it never writes.
    assign ram_en    = vga_read_en | pend_grant;
    assign ram_we    = pend_grant & cmd_we_reg;
    assign ram_addr  = vga_read_en ? vga_read_addr : cmd_addr_reg;
    assign ram_wdata = cmd_wdata_reg;

    assign vga_read_data = prev_vga_reg ? ram_rdata : vga_hold_reg;

    assign cpu_busy    = ~in_idle;
    assign cpu_ack     = (state_reg == ST_ACK);
    assign cpu_rdata   = cpu_rdata_reg;
    assign cpu_overrun = overrun_reg;

endmodule

// File: tb/tb_screen_ram_arbiter.sv
// Directed bench for screen_ram_arbiter: expected RAM writes, CPU acks and VGA
// fetch data are queued by the stimulus and checked by a negedge monitor.
module tb_screen_ram_arbiter;

    typedef struct packed {
        logic [10:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct packed {
        logic       we;
        logic [7:0] rdata;
    } ack_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        vga_read_en;
    logic [10:0] vga_read_addr;
    logic [7:0]  vga_read_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_overrun;
    logic        ram_en;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  stat_max_wait;

    logic [7:0]  mem [0:2047];
    logic [7:0]  model_q = 8'h00;
    logic        ovr_en = 1'b0;
    logic [7:0]  ovr_data = 8'h00;
    logic        vga_due = 1'b0;

    wr_t         wr_q[$];
    ack_t        ack_q[$];
    logic [7:0]  vga_q[$];

    int checks = 0;
    int errors = 0;
    int ack_seen = 0;

    wr_t         mon_w;
    ack_t        mon_a;
    logic [7:0]  mon_v;

    always #5 clk = ~clk;

    screen_ram_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .vga_read_en   (vga_read_en),
        .vga_read_addr (vga_read_addr),
        .vga_read_data (vga_read_data),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_busy      (cpu_busy),
        .cpu_ack       (cpu_ack),
        .cpu_rdata     (cpu_rdata),
        .cpu_overrun   (cpu_overrun),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .stat_max_wait (stat_max_wait)
    );

    // Synchronous single-port RAM model, 1-cycle read latency.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                mem[ram_addr] <= ram_wdata;
            model_q <= mem[ram_addr];
        end
    end
    assign ram_rdata = ovr_en ? ovr_data : model_q;

    always @(posedge clk)
        vga_due <= reset ? vga_read_en : 1'b0;

    function automatic logic [7:0] pattern(input logic [10:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset) begin
            if (ram_we) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL ram_write unexpected: addr=%h data=%h, none required", ram_addr, ram_wdata);
                end else begin
                    mon_w = wr_q.pop_front();
                    if (ram_addr !== mon_w.addr || ram_wdata !== mon_w.data) begin
                        errors++;
                        $display("FAIL ram_write: got addr=%h data=%h, required addr=%h data=%h",
                                 ram_addr, ram_wdata, mon_w.addr, mon_w.data);
                    end else
                        $display("RAM WR addr=%h data=%h ok", ram_addr, ram_wdata);
                end
            end
            if (cpu_ack) begin
                ack_seen++;
                checks++;
                if (ack_q.size() == 0) begin
                    errors++;
                    $display("FAIL cpu_ack unexpected: rdata=%h, no command outstanding", cpu_rdata);
                end else begin
                    mon_a = ack_q.pop_front();
                    if (!mon_a.we && cpu_rdata !== mon_a.rdata) begin
                        errors++;
                        $display("FAIL cpu_read_data: got %h, required %h", cpu_rdata, mon_a.rdata);
                    end else
                        $display("CPU ACK we=%0b rdata=%h ok", mon_a.we, cpu_rdata);
                end
            end
            if (vga_due) begin
                checks++;
                if (vga_q.size() == 0) begin
                    errors++;
                    $display("FAIL vga_read unexpected: data=%h, no fetch queued", vga_read_data);
                end else begin
                    mon_v = vga_q.pop_front();
                    if (vga_read_data !== mon_v) begin
                        errors++;
                        $display("FAIL vga_read_data: got %h, required %h", vga_read_data, mon_v);
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (cpu_busy && n < budget) begin
            tick;
            #2;
            n++;
        end
        checks++;
        if (cpu_busy) begin
            errors++;
            $display("FAIL wait_idle: cpu_busy=1 after %0d cycles, required 0", budget);
        end
    endtask

    task automatic vga_fetch(input logic [10:0] a, input logic [7:0] exp);
        vga_read_en   = 1'b1;
        vga_read_addr = a;
        vga_q.push_back(exp);
    endtask

    initial begin
        int acks_before;
        for (int i = 0; i < 2048; i++)
            mem[i] = pattern(11'(i));
        mem[11'h040] = 8'hC3;

        reset = 1'b0;
        vga_read_en = 1'b0; vga_read_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", 32'(cpu_busy), 32'h0);
        chk("rst_ack", 32'(cpu_ack), 32'h0);
        chk("rst_overrun", 32'(cpu_overrun), 32'h0);
        chk("rst_rdata", 32'(cpu_rdata), 32'h0);
        chk("rst_stat", 32'(stat_max_wait), 32'h0);
        chk("rst_vga_data", 32'(vga_read_data), 32'h0);
        tick;
        reset = 1'b1;

        // Uncontended write: RAM write in cycle 1, ack in cycle 2.
        tick;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h200; cpu_wdata = 8'h5A;
        wr_q.push_back('{addr: 11'h200, data: 8'h5A});
        ack_q.push_back('{we: 1'b1, rdata: 8'h00});
        tick; cpu_req = 1'b0; #2;
        chk("wr_c1_we", 32'(ram_we), 32'h1);
        chk("wr_c1_addr", 32'(ram_addr), 32'h200);
        chk("wr_c1_wdata", 32'(ram_wdata), 32'h5A);
        chk("wr_c1_busy", 32'(cpu_busy), 32'h1);
        tick; #2;
        chk("wr_c2_ack", 32'(cpu_ack), 32'h1);
        chk("wr_c2_busy", 32'(cpu_busy), 32'h1);
        tick; #2;
        chk("wr_c3_busy", 32'(cpu_busy), 32'h0);

        // Uncontended read back: RAM read cycle 1, ack cycle 3.
        tick;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h200;
        ack_q.push_back('{we: 1'b0, rdata: 8'h5A});
        tick; cpu_req = 1'b0; #2;
        chk("rd_c1_en", 32'(ram_en), 32'h1);
        chk("rd_c1_we", 32'(ram_we), 32'h0);
        chk("rd_c1_addr", 32'(ram_addr), 32'h200);
        tick; #2;
        chk("rd_c2_ack", 32'(cpu_ack), 32'h0);
        tick; #2;
        chk("rd_c3_ack", 32'(cpu_ack), 32'h1);
        chk("rd_c3_rdata", 32'(cpu_rdata), 32'h5A);
        tick; #2;
        chk("rd_stat", 32'(stat_max_wait), 32'h0);

        // Write pending behind 10 cycles of VGA fetches.
        tick;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h300; cpu_wdata = 8'h77;
        wr_q.push_back('{addr: 11'h300, data: 8'h77});
        ack_q.push_back('{we: 1'b1, rdata: 8'h00});
        for (int i = 0; i < 10; i++) begin
            tick;
            cpu_req = 1'b0;
            vga_fetch(11'h010 + 11'(i), pattern(11'h010 + 11'(i)));
            #2;
            chk("vga_blocks_we", 32'(ram_we), 32'h0);
        end
        tick; vga_read_en = 1'b0; #2;
        chk("contend_wr_we", 32'(ram_we), 32'h1);
        chk("contend_wr_addr", 32'(ram_addr), 32'h300);
        wait_idle(10);
        chk("stat_10", 32'(stat_max_wait), 32'hA);

        // Read pending behind 300 VGA cycles: statistic saturates.
        tick;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h300;
        ack_q.push_back('{we: 1'b0, rdata: 8'h77});
        for (int i = 0; i < 300; i++) begin
            tick;
            cpu_req = 1'b0;
            vga_fetch(11'h400 + 11'(i), pattern(11'h400 + 11'(i)));
        end
        #2;
        chk("long_busy", 32'(cpu_busy), 32'h1);
        tick; vga_read_en = 1'b0;
        wait_idle(10);
        chk("stat_sat", 32'(stat_max_wait), 32'hFF);

        // Second request while busy is dropped and flagged.
        chk("pre_overrun", 32'(cpu_overrun), 32'h0);
        acks_before = ack_seen;
        tick;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h111; cpu_wdata = 8'h22;
        wr_q.push_back('{addr: 11'h111, data: 8'h22});
        ack_q.push_back('{we: 1'b1, rdata: 8'h00});
        tick;
        cpu_addr = 11'h112; cpu_wdata = 8'h33;
        tick; cpu_req = 1'b0; #2;
        chk("overrun_set", 32'(cpu_overrun), 32'h1);
        wait_idle(10);
        repeat (3) tick;
        chk("overrun_one_ack", 32'(ack_seen - acks_before), 32'h1);
        chk("overrun_no_write", 32'(mem[11'h112]), 32'(pattern(11'h112)));

        // VGA data holds after the strobe drops.
        tick; vga_fetch(11'h040, 8'hC3);
        tick; vga_read_en = 1'b0;
        tick; ovr_en = 1'b1; ovr_data = 8'h00; #2;
        chk("vga_hold_a", 32'(vga_read_data), 32'hC3);
        tick; #2;
        chk("vga_hold_b", 32'(vga_read_data), 32'hC3);
        ovr_en = 1'b0;

        // Reset while the command is pending.
        tick;
        vga_read_en = 1'b1; vga_read_addr = 11'h500;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h150; cpu_wdata = 8'h99;
        tick; cpu_req = 1'b0; #2;
        chk("pend_busy", 32'(cpu_busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(cpu_busy), 32'h0);
        chk("mid_rst_ack", 32'(cpu_ack), 32'h0);
        chk("mid_rst_overrun", 32'(cpu_overrun), 32'h0);
        chk("mid_rst_stat", 32'(stat_max_wait), 32'h0);
        chk("mid_rst_rdata", 32'(cpu_rdata), 32'h0);
        vga_read_en = 1'b0;
        vga_q.delete();
        tick; tick;
        reset = 1'b1;
        repeat (4) tick;
        #2;
        chk("post_rst_busy", 32'(cpu_busy), 32'h0);
        chk("post_rst_unwritten", 32'(mem[11'h150]), 32'(pattern(11'h150)));

        chk("total_acks", 32'(ack_seen), 32'h5);
        chk("wr_q_empty", 32'(wr_q.size()), 32'h0);
        chk("ack_q_empty", 32'(ack_q.size()), 32'h0);
        chk("vga_q_empty", 32'(vga_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
